dmac_ctrl_arb: RTL and testbench



---
 rtl/dmac_ctrl_arb.sv | 138 +++++++++++++
 tb/tb_dmac_ctrl_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmac_ctrl_arb.sv
// Round-robin arbiter sharing the DMA-controller command port among NB_REQ requesters,
// with an in-order ID FIFO for response routing. Define DMAC_ARB_FC_PRIO_EN for FC strict priority.
module dmac_ctrl_arb #(
  parameter int NB_REQ     = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_OUTST  = 4,
  parameter int ID_WIDTH   = $clog2(NB_REQ)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_REQ-1:0]                req_i,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]     add_i,
  input  logic [NB_REQ-1:0]                wen_i,
  input  logic [NB_REQ*BE_WIDTH-1:0]       be_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0]     wdata_i,
  output logic [NB_REQ-1:0]                gnt_o,
  output logic [NB_REQ-1:0]                r_valid_o,
  output logic [NB_REQ*DATA_WIDTH-1:0]     r_rdata_o,
  output logic [NB_REQ-1:0]                r_opc_o,
  output logic                             tgt_req_o,
  output logic [ADDR_WIDTH-1:0]            tgt_add_o,
  output logic                             tgt_wen_o,
  output logic [BE_WIDTH-1:0]              tgt_be_o,
  output logic [DATA_WIDTH-1:0]            tgt_wdata_o,
  output logic [ID_WIDTH-1:0]              tgt_id_o,
  input  logic                             tgt_gnt_i,
  input  logic                             tgt_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            tgt_r_rdata_i,
  input  logic                             tgt_r_opc_i,
  output logic [$clog2(MAX_OUTST):0]       outst_o,
  output logic                             err_o
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic                r_lock_vld;
  logic [ID_WIDTH-1:0] r_lock_idx;
  logic [ID_WIDTH-1:0] r_fifo [MAX_OUTST];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;

  logic [ID_WIDTH-1:0] w_arb_idx;
  logic                w_found;
  logic [ID_WIDTH-1:0] w_sel;
  logic                w_full;
  logic                w_empty;
  logic                w_hs;
  logic                w_pop;
  logic                w_fc_win;
  logic [ID_WIDTH-1:0] w_rr_next;

  always_comb begin
    w_arb_idx = '0;
    w_found   = 1'b0;
    w_fc_win  = 1'b0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      int unsigned idx;
      idx = int'(r_rr_ptr) + i;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (!w_found && req_i[idx]) begin
        w_found   = 1'b1;
        w_arb_idx = ID_WIDTH'(idx);
      end
    end
`ifdef DMAC_ARB_FC_PRIO_EN
    if (req_i[NB_REQ-1]) begin
      w_arb_idx = ID_WIDTH'(NB_REQ-1);
      w_fc_win  = 1'b1;
    end
`endif
  end

  assign w_sel     = r_lock_vld ? r_lock_idx : w_arb_idx;
  assign w_full    = (r_cnt == CNT_W'(MAX_OUTST));
  assign w_empty   = (r_cnt == '0);
  assign tgt_req_o = rst_ni & (r_lock_vld | (|req_i)) & ~w_full;
  assign w_hs      = tgt_req_o & tgt_gnt_i;
  assign w_pop     = rst_ni & tgt_r_valid_i & ~w_empty;

  assign tgt_id_o    = w_sel;
  assign tgt_add_o   = add_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign tgt_wen_o   = wen_i[w_sel];
  assign tgt_be_o    = be_i[w_sel*BE_WIDTH +: BE_WIDTH];
  assign tgt_wdata_o = wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];

  assign r_rdata_o = {NB_REQ{tgt_r_rdata_i}};
  assign r_opc_o   = {NB_REQ{tgt_r_opc_i}};
  assign outst_o   = r_cnt;
  assign err_o     = r_err;

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (w_hs)  gnt_o[w_sel] = 1'b1;
    if (w_pop) r_valid_o[r_fifo[r_rptr]] = 1'b1;
  end

  // An FC priority win leaves the round-robin pointer where it was; a locked
  // FC grant can only originate from such a win, so the lock path needs no extra flag.
  always_comb begin
    w_rr_next = (w_sel == ID_WIDTH'(NB_REQ-1)) ? '0 : w_sel + ID_WIDTH'(1);
`ifdef DMAC_ARB_FC_PRIO_EN
    if (w_fc_win || (w_sel == ID_WIDTH'(NB_REQ-1))) w_rr_next = r_rr_ptr;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_lock_vld     <= 1'b0;
        r_rr_ptr       <= w_rr_next;
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= r_wptr + PTR_W'(1);
      end else if (tgt_req_o) begin
        r_lock_vld <= 1'b1;
        r_lock_idx <= w_sel;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_hs) - CNT_W'(w_pop);
      if (tgt_r_valid_i && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmac_ctrl_arb.sv
// Directed self-checking bench for dmac_ctrl_arb (default parameters).
module tb_dmac_ctrl_arb;
  localparam int NB = 10;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NB-1:0]     req;
  logic [NB*AW-1:0]  add;
  logic [NB-1:0]     wen;
  logic [NB*BW-1:0]  be;
  logic [NB*DW-1:0]  wdata;
  logic [NB-1:0]     gnt_o;
  logic [NB-1:0]     r_valid_o;
  logic [NB*DW-1:0]  r_rdata_o;
  logic [NB-1:0]     r_opc_o;
  logic              tgt_req_o;
  logic [AW-1:0]     tgt_add_o;
  logic              tgt_wen_o;
  logic [BW-1:0]     tgt_be_o;
  logic [DW-1:0]     tgt_wdata_o;
  logic [3:0]        tgt_id_o;
  logic              tgt_gnt;
  logic              tgt_r_valid;
  logic [DW-1:0]     tgt_r_rdata;
  logic              tgt_r_opc;
  logic [2:0]        outst_o;
  logic              err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmac_ctrl_arb #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .r_opc_o(r_opc_o), .tgt_req_o(tgt_req_o), .tgt_add_o(tgt_add_o), .tgt_wen_o(tgt_wen_o),
    .tgt_be_o(tgt_be_o), .tgt_wdata_o(tgt_wdata_o), .tgt_id_o(tgt_id_o), .tgt_gnt_i(tgt_gnt),
    .tgt_r_valid_i(tgt_r_valid), .tgt_r_rdata_i(tgt_r_rdata), .tgt_r_opc_i(tgt_r_opc),
    .outst_o(outst_o), .err_o(err_o)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic w);
    add[p*AW +: AW]   = a;
    wen[p]            = w;
    be[p*BW +: BW]    = 4'hF;
    wdata[p*DW +: DW] = a ^ 32'h5555_AAAA;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(); req = '0; tgt_gnt = 0; tgt_r_valid = 1; #1;
    end
    cyc(); tgt_r_valid = 0; #1;
    checks++; if (outst_o !== 3'd0) begin failures++; $display("FAIL drain_outst got=%0d exp=0", outst_o); end
  endtask

  task automatic test_reset();
    rst_n = 0; req = '1; tgt_gnt = 1; tgt_r_valid = 1;
    repeat (2) cyc();
    #1;
    checks++; if (tgt_req_o !== 1'b0) begin failures++; $display("FAIL rst_tgt_req got=%b exp=0", tgt_req_o); end
    checks++; if (gnt_o !== '0) begin failures++; $display("FAIL rst_gnt got=%h exp=0", gnt_o); end
    checks++; if (r_valid_o !== '0) begin failures++; $display("FAIL rst_rvalid got=%h exp=0", r_valid_o); end
    checks++; if (outst_o !== 3'd0) begin failures++; $display("FAIL rst_outst got=%0d exp=0", outst_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_o); end
    cyc(); rst_n = 1; req = '0; tgt_gnt = 0; tgt_r_valid = 0;
  endtask

  task automatic test_single();
    cyc(); req = NB'(1) << 3; set_port(3, 32'h1000_0004, 1'b1); tgt_gnt = 1; #1;
    checks++; if (gnt_o !== (NB'(1) << 3)) begin failures++; $display("FAIL single_gnt got=%h exp=%h", gnt_o, NB'(1) << 3); end
    checks++; if (tgt_id_o !== 4'd3) begin failures++; $display("FAIL single_id got=%0d exp=3", tgt_id_o); end
    checks++; if (tgt_add_o !== 32'h1000_0004 || tgt_wen_o !== 1'b1) begin failures++; $display("FAIL single_payload got=%h/%b exp=10000004/1", tgt_add_o, tgt_wen_o); end
    cyc(); req = '0; tgt_gnt = 0; #1;
    checks++; if (outst_o !== 3'd1) begin failures++; $display("FAIL single_outst1 got=%0d exp=1", outst_o); end
    cyc(); tgt_r_valid = 1; tgt_r_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (r_valid_o !== (NB'(1) << 3)) begin failures++; $display("FAIL single_rvalid got=%h exp=%h", r_valid_o, NB'(1) << 3); end
    checks++; if (r_rdata_o[3*DW +: DW] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", r_rdata_o[3*DW +: DW]); end
    cyc(); tgt_r_valid = 0; #1;
    checks++; if (outst_o !== 3'd0) begin failures++; $display("FAIL single_outst0 got=%0d exp=0", outst_o); end
  endtask

  task automatic test_round_robin();
    for (int p = 0; p < 3; p++) set_port(p, 32'h2000_0000 + p, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc(); req = NB'(7); tgt_gnt = 1; tgt_r_valid = (k > 0); #1;
      checks++; if (gnt_o !== (NB'(1) << (k % 3))) begin failures++; $display("FAIL rr_gnt%0d got=%h exp=%h", k, gnt_o, NB'(1) << (k % 3)); end
      if (k > 0) begin
        checks++; if (r_valid_o !== (NB'(1) << ((k - 1) % 3))) begin failures++; $display("FAIL rr_rvalid%0d got=%h exp=%h", k, r_valid_o, NB'(1) << ((k - 1) % 3)); end
      end
    end
    drain(1);
  endtask

  task automatic test_lock();
    set_port(0, 32'h3000_0000, 1'b1);
    cyc(); req = NB'(1); tgt_gnt = 1; #1;
    checks++; if (gnt_o !== NB'(1)) begin failures++; $display("FAIL lock_pre_gnt got=%h exp=001", gnt_o); end
    set_port(5, 32'h5555_0050, 1'b0); set_port(1, 32'h1111_0010, 1'b1);
    cyc(); req = NB'(1) << 5; tgt_gnt = 0; #1;
    checks++; if (tgt_id_o !== 4'd5 || tgt_req_o !== 1'b1 || gnt_o !== '0) begin failures++; $display("FAIL lock_c0 got=id%0d req%b gnt%h exp=id5 req1 gnt0", tgt_id_o, tgt_req_o, gnt_o); end
    cyc(); req = (NB'(1) << 5) | (NB'(1) << 1); #1;
    checks++; if (tgt_id_o !== 4'd5) begin failures++; $display("FAIL lock_c1_id got=%0d exp=5", tgt_id_o); end
    checks++; if (tgt_add_o !== 32'h5555_0050 || tgt_wdata_o !== (32'h5555_0050 ^ 32'h5555_AAAA)) begin failures++; $display("FAIL lock_c1_payload got=%h/%h exp=55550050", tgt_add_o, tgt_wdata_o); end
    cyc(); #1;
    checks++; if (tgt_id_o !== 4'd5) begin failures++; $display("FAIL lock_c2_id got=%0d exp=5", tgt_id_o); end
    cyc(); tgt_gnt = 1; #1;
    checks++; if (gnt_o !== (NB'(1) << 5)) begin failures++; $display("FAIL lock_gnt5 got=%h exp=%h", gnt_o, NB'(1) << 5); end
    cyc(); req = NB'(1) << 1; #1;
    checks++; if (gnt_o !== (NB'(1) << 1)) begin failures++; $display("FAIL lock_gnt1 got=%h exp=%h", gnt_o, NB'(1) << 1); end
    drain(3);
  endtask

  task automatic test_fifo_full();
    set_port(2, 32'h2222_0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(); req = NB'(1) << 2; tgt_gnt = 1; #1;
      checks++; if (gnt_o !== (NB'(1) << 2)) begin failures++; $display("FAIL full_fill%0d got=%h exp=%h", k, gnt_o, NB'(1) << 2); end
    end
    cyc(); #1;
    checks++; if (outst_o !== 3'd4 || tgt_req_o !== 1'b0 || gnt_o !== '0) begin failures++; $display("FAIL full_block got=outst%0d req%b gnt%h exp=outst4 req0 gnt0", outst_o, tgt_req_o, gnt_o); end
    cyc(); tgt_r_valid = 1; #1;
    checks++; if (tgt_req_o !== 1'b0) begin failures++; $display("FAIL full_nobypass got=%b exp=0", tgt_req_o); end
    checks++; if (r_valid_o !== (NB'(1) << 2)) begin failures++; $display("FAIL full_rvalid got=%h exp=%h", r_valid_o, NB'(1) << 2); end
    cyc(); tgt_r_valid = 0; #1;
    checks++; if (outst_o !== 3'd3 || tgt_req_o !== 1'b1 || gnt_o !== (NB'(1) << 2)) begin failures++; $display("FAIL full_reopen got=outst%0d req%b gnt%h exp=outst3 req1 gnt004", outst_o, tgt_req_o, gnt_o); end
    cyc(); req = '0; tgt_gnt = 0; #1;
    checks++; if (outst_o !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", outst_o); end
    drain(4);
  endtask

  task automatic test_push_pop();
    cyc(); req = NB'(1) << 4; tgt_gnt = 1; #1;
    cyc(); req = NB'(1) << 6; #1;
    checks++; if (gnt_o !== (NB'(1) << 6)) begin failures++; $display("FAIL pp_gnt6 got=%h exp=%h", gnt_o, NB'(1) << 6); end
    cyc(); req = NB'(1) << 7; tgt_r_valid = 1; #1;
    checks++; if (outst_o !== 3'd2) begin failures++; $display("FAIL pp_outst_before got=%0d exp=2", outst_o); end
    checks++; if (r_valid_o !== (NB'(1) << 4) || gnt_o !== (NB'(1) << 7)) begin failures++; $display("FAIL pp_route got=rv%h gnt%h exp=rv010 gnt080", r_valid_o, gnt_o); end
    cyc(); req = '0; tgt_gnt = 0; tgt_r_valid = 0; #1;
    checks++; if (outst_o !== 3'd2) begin failures++; $display("FAIL pp_outst_after got=%0d exp=2", outst_o); end
    drain(2);
  endtask

  task automatic test_spurious();
    cyc(); tgt_r_valid = 1; #1;
    checks++; if (r_valid_o !== '0) begin failures++; $display("FAIL spur_rvalid got=%h exp=0", r_valid_o); end
    cyc(); tgt_r_valid = 0; #1;
    checks++; if (err_o !== 1'b1 || outst_o !== 3'd0) begin failures++; $display("FAIL spur_err got=err%b outst%0d exp=err1 outst0", err_o, outst_o); end
    cyc(); cyc(); #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b exp=1", err_o); end
  endtask

  task automatic test_fc_prio();
    logic [3:0] exp_id;
`ifdef DMAC_ARB_FC_PRIO_EN
    exp_id = 4'd9;
`else
    exp_id = 4'd0;
`endif
    cyc(); req = NB'(1) << 9; tgt_gnt = 1; #1;
    checks++; if (gnt_o !== (NB'(1) << 9)) begin failures++; $display("FAIL fc_pre_gnt got=%h exp=200", gnt_o); end
    cyc(); req = NB'(1) | (NB'(1) << 9); #1;
    checks++; if (tgt_id_o !== exp_id || gnt_o !== (NB'(1) << exp_id)) begin failures++; $display("FAIL fc_winner got=id%0d gnt%h exp=id%0d", tgt_id_o, gnt_o, exp_id); end
    drain(2);
  endtask

  task automatic test_reset_mid();
    cyc(); req = NB'(1) << 2; tgt_gnt = 1; #1;
    cyc(); rst_n = 0; req = NB'(1) << 3; #1;
    checks++; if (tgt_req_o !== 1'b0 || gnt_o !== '0) begin failures++; $display("FAIL rmid_gated got=req%b gnt%h exp=0", tgt_req_o, gnt_o); end
    cyc(); rst_n = 1; req = '0; tgt_gnt = 0; #1;
    checks++; if (outst_o !== 3'd0 || err_o !== 1'b0) begin failures++; $display("FAIL rmid_clear got=outst%0d err%b exp=0/0", outst_o, err_o); end
  endtask

  initial begin
    add = '0; wen = '0; be = '0; wdata = '0;
    tgt_r_rdata = '0; tgt_r_opc = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_push_pop();
    test_spurious();
    test_fc_prio();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
